// File: rtl/ring_digit_scanner_if.sv
// Phase/digit inputs and display/status outputs of the digit scanner.
// master: phase source + display consumer side; slave: scanner side.
//   Phase_in   one-hot ring phase        Digits_in  packed hex digits
//   Clear_err  sync clear of error flags Seg_out    7-seg segments a..g
//   Digit_en   digit enable              Rev_count  completed rotations
//   Err_onehot sticky bad-code flag      Err_seq    sticky order flag
interface ring_digit_scanner_if #(
    parameter int NUM_PH = 4,
    parameter int REV_W  = 8
);
    logic [NUM_PH-1:0]   Phase_in;
    logic [4*NUM_PH-1:0] Digits_in;
    logic                Clear_err;
    logic [6:0]          Seg_out;
    logic [NUM_PH-1:0]   Digit_en;
    logic [REV_W-1:0]    Rev_count;
    logic                Err_onehot;
    logic                Err_seq;

    modport master (
        output Phase_in, Digits_in, Clear_err,
        input  Seg_out, Digit_en, Rev_count,
        input  Err_onehot, Err_seq
    );

    modport slave (
        input  Phase_in, Digits_in, Clear_err,
        output Seg_out, Digit_en, Rev_count,
        output Err_onehot, Err_seq
    );
endinterface

// File: rtl/ring_digit_scanner.sv
// Multiplexes NUM_PH hex digits on a 7-seg bus from a one-hot ring phase,
// with blanking dead-time, phase-stream policing and a revolution counter.
// Ports: Clock, Reset (async, active-high), bus (ring_digit_scanner_if.slave).
module ring_digit_scanner #(
    parameter int NUM_PH    = 4,
    parameter int BLANK_CYC = 2,
    parameter int REV_W     = 8
) (
    input logic                  Clock,
    input logic                  Reset,
    ring_digit_scanner_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    localparam int CW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [CW-1:0] CNT_INIT =
        CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

    function automatic logic [6:0] hex7(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
        endcase
        return s;
    endfunction

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NUM_PH-1:0] ph_q, ph_d;
    logic [3:0]        dig_q, dig_d;
    logic [6:0]        seg_q, seg_d;
    logic [NUM_PH-1:0] den_q, den_d;
    logic [REV_W-1:0]  rev_q, rev_d;
    logic              eoh_q, eoh_d;
    logic              esq_q, esq_d;

    logic              change, valid;
    logic              err_oh, err_sq;
    logic [NUM_PH-1:0] rot;
    logic [3:0]        new_dig;

    assign change = bus.Phase_in != ph_q;
    assign valid  = $countones(bus.Phase_in) == 1;
    assign rot    = {ph_q[NUM_PH-2:0], ph_q[NUM_PH-1]};

    // Digit slice selected by the incoming phase.
    always_comb begin
        new_dig = '0;
        for (int i = 0; i < NUM_PH; i++)
            if (bus.Phase_in[i])
                new_dig = bus.Digits_in[4*i +: 4];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ph_d    = ph_q;
        dig_d   = dig_q;
        seg_d   = seg_q;
        den_d   = den_q;
        rev_d   = rev_q;
        err_oh  = 1'b0;
        err_sq  = 1'b0;
        unique case (1'b1)
            change && !valid: begin
                state_d = IDLE;
                cnt_d   = '0;
                ph_d    = bus.Phase_in;
                dig_d   = new_dig;
                seg_d   = '0;
                den_d   = '0;
                err_oh  = 1'b1;
            end
            change && valid: begin
                ph_d  = bus.Phase_in;
                dig_d = new_dig;
                // Order is only meaningful once a valid phase is known.
                if (state_q != IDLE) begin
                    err_sq = bus.Phase_in != rot;
                    if (ph_q[NUM_PH-1] && bus.Phase_in[0])
                        rev_d = rev_q + 1'b1;
                end
                if (BLANK_CYC == 0) begin
                    state_d = DRIVE;
                    seg_d   = hex7(new_dig);
                    den_d   = bus.Phase_in;
                end else begin
                    state_d = BLANK;
                    cnt_d   = CNT_INIT;
                    seg_d   = '0;
                    den_d   = '0;
                end
            end
            !change && state_q == BLANK: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = DRIVE;
                    seg_d   = hex7(dig_q);
                    den_d   = ph_q;
                end
            end
            default: ;
        endcase
        // A new error on the clearing edge still lands.
        eoh_d = (eoh_q & ~bus.Clear_err) | err_oh;
        esq_d = (esq_q & ~bus.Clear_err) | err_sq;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ph_q    <= '0;
            dig_q   <= '0;
            seg_q   <= '0;
            den_q   <= '0;
            rev_q   <= '0;
            eoh_q   <= 1'b0;
            esq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            dig_q   <= dig_d;
            seg_q   <= seg_d;
            den_q   <= den_d;
            rev_q   <= rev_d;
            eoh_q   <= eoh_d;
            esq_q   <= esq_d;
        end
    end

    assign bus.Seg_out    = seg_q;
    assign bus.Digit_en   = den_q;
    assign bus.Rev_count  = rev_q;
    assign bus.Err_onehot = eoh_q;
    assign bus.Err_seq    = esq_q;
endmodule
